// File: rtl/reg_scoreboard_pkg.sv
// Shared scoreboard sizing and the opcode classes ID uses to derive issue_fwd.
package reg_scoreboard_pkg;

    localparam int unsigned NREGS     = 32;
    localparam int unsigned ADDR_BITS = 5;
    localparam int unsigned CNT_W     = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    // Long-latency results (loads, MUL/DIV) cannot be served by the EXE/MEM bypass.
    function automatic logic is_long_latency(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPC_LOAD) ||
               (((opcode == OPC_OP) || (opcode == OPC_OP32)) && (funct7 == F7_MULDIV));
    endfunction

endpackage

// File: rtl/reg_scoreboard_entry.sv
// One register's outstanding-write counter and non-forwardable flag.
module reg_scoreboard_entry
    import reg_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec_wb,
    input  logic             dec_kill,
    input  logic             nf_set,
    output logic [CNT_W-1:0] cnt,
    output logic             nf,
    output logic             underflow_c
);

    localparam int unsigned SUM_W = CNT_W + 2;

    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt_next;
    logic             nf_next;

    // Net update; MSB is the sign, the bit below it catches any overflow.
    always_comb begin
        sum         = SUM_W'(cnt) + SUM_W'(inc) - SUM_W'(dec_wb) - SUM_W'(dec_kill);
        underflow_c = sum[SUM_W-1];
        cnt_next    = sum[CNT_W-1:0];
        nf_next     = nf;
        if (underflow_c) begin
            cnt_next = '0;
        end else if (sum[CNT_W]) begin
            cnt_next = CNT_MAX;
        end
        if (cnt_next == '0) begin
            nf_next = 1'b0;
        end else if (inc && nf_set) begin
            nf_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            nf  <= 1'b0;
        end else begin
            cnt <= cnt_next;
            nf  <= nf_next;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register write scoreboard feeding the ID-stage stall decision.
// Optional SCOREBOARD_WB_BYPASS_EN lets a final writeback mask busy in the same cycle.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic [ADDR_BITS-1:0] issue_rd,
    input  logic                 issue_fwd,
    input  logic                 wb_valid,
    input  logic [ADDR_BITS-1:0] wb_rd,
    input  logic                 kill_valid,
    input  logic [ADDR_BITS-1:0] kill_rd,
    input  logic [ADDR_BITS-1:0] rs1_addr,
    input  logic [ADDR_BITS-1:0] rs2_addr,
    input  logic [ADDR_BITS-1:0] rs3_addr,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 rs3_busy,
    output logic                 issue_stall,
    output logic                 sb_err
);

    logic [CNT_W-1:0] cnt [NREGS];
    logic [NREGS-1:0] nf;
    logic [NREGS-1:0] underflow;
    logic [NREGS-1:0] wb_free;
    logic [NREGS-1:0] busy;
    logic             sat;
    logic             inc_en;

    assign cnt[0]       = '0;
    assign nf[0]        = 1'b0;
    assign underflow[0] = 1'b0;

    // Busy = pending write that the bypass network cannot serve.
    always_comb begin
        wb_free = '0;
`ifdef SCOREBOARD_WB_BYPASS_EN
        for (int unsigned r = 1; r < NREGS; r++) begin
            wb_free[r] = wb_valid && (wb_rd == ADDR_BITS'(r)) && (cnt[r] == CNT_W'(1));
        end
`endif
        busy = '0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            busy[r] = (cnt[r] != '0) && nf[r] && !wb_free[r];
        end
    end

    // A saturated counter only accepts a new issue when a writeback frees a slot.
    always_comb begin
        rs1_busy    = busy[rs1_addr];
        rs2_busy    = busy[rs2_addr];
        rs3_busy    = busy[rs3_addr];
        sat         = (issue_rd != '0) && (cnt[issue_rd] == CNT_MAX) &&
                      !(wb_valid && (wb_rd == issue_rd));
        issue_stall = issue_valid && (rs1_busy || rs2_busy || rs3_busy || sat);
        inc_en      = issue_valid && (issue_rd != '0) && !issue_stall;
    end

    for (genvar r = 1; r < NREGS; r++) begin : g_entry
        reg_scoreboard_entry u_entry (
            .clk         (clk),
            .rst_n       (rst_n),
            .inc         (inc_en && (issue_rd == ADDR_BITS'(r))),
            .dec_wb      (wb_valid && (wb_rd == ADDR_BITS'(r))),
            .dec_kill    (kill_valid && (kill_rd == ADDR_BITS'(r))),
            .nf_set      (!issue_fwd),
            .cnt         (cnt[r]),
            .nf          (nf[r]),
            .underflow_c (underflow[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_err <= 1'b0;
        end else if (|underflow) begin
            sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard; expectations follow the bypass macro when defined.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 issue_valid;
    logic [ADDR_BITS-1:0] issue_rd;
    logic                 issue_fwd;
    logic                 wb_valid;
    logic [ADDR_BITS-1:0] wb_rd;
    logic                 kill_valid;
    logic [ADDR_BITS-1:0] kill_rd;
    logic [ADDR_BITS-1:0] rs1_addr;
    logic [ADDR_BITS-1:0] rs2_addr;
    logic [ADDR_BITS-1:0] rs3_addr;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic                 rs3_busy;
    logic                 issue_stall;
    logic                 sb_err;

    int checks = 0;
    int errors = 0;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    reg_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_fwd   (issue_fwd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .kill_valid  (kill_valid),
        .kill_rd     (kill_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs3_addr    (rs3_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rs3_busy    (rs3_busy),
        .issue_stall (issue_stall),
        .sb_err      (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rd = '0; issue_fwd = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; kill_valid = 1'b0; kill_rd = '0;
        rs1_addr = '0; rs2_addr = '0; rs3_addr = '0;
    endtask

    // Advance one clock; inputs change 1ns after the rising edge, checks follow #1 later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [ADDR_BITS-1:0] rd, input logic fwd);
        idle();
        issue_valid = 1'b1; issue_rd = rd; issue_fwd = fwd;
        cyc();
        idle();
    endtask

    task automatic wb(input logic [ADDR_BITS-1:0] rd);
        idle();
        wb_valid = 1'b1; wb_rd = rd;
        cyc();
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #2;
        check("rst_busy1", 32'(rs1_busy), 0);
        check("rst_stall", 32'(issue_stall), 0);
        check("rst_err", 32'(sb_err), 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Reset with in-flight state
        issue(5'd5, 1'b0);
        issue(5'd5, 1'b0);
        check("t1_cnt5_pre", 32'(dut.cnt[5]), 2);
        rs1_addr = 5'd5;
        #1;
        check("t1_busy_pre", 32'(rs1_busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check("t1_busy_async", 32'(rs1_busy), 0);
        check("t1_err_async", 32'(sb_err), 0);
        check("t1_cnt5_async", 32'(dut.cnt[5]), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("t1_cnt5_post", 32'(dut.cnt[5]), 0);
        idle();

        // Load-use
        issue(5'd5, 1'b0);
        issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd5;
        #1;
        check("t2_busy", 32'(rs1_busy), 1);
        check("t2_stall", 32'(issue_stall), 1);
        cyc();
        check("t2_busy_hold", 32'(rs1_busy), 1);
        wb_valid = 1'b1; wb_rd = 5'd5;
        #1;
        check("t2_busy_wb", 32'(rs1_busy), 32'(!BYP));
        check("t2_stall_wb", 32'(issue_stall), 32'(!BYP));
        cyc();
        wb_valid = 1'b0; wb_rd = '0;
        #1;
        check("t2_busy_after", 32'(rs1_busy), 0);
        check("t2_stall_after", 32'(issue_stall), 0);
        check("t2_cnt5", 32'(dut.cnt[5]), 0);
        idle();

        // Forwardable ALU result
        issue(5'd7, 1'b1);
        issue_valid = 1'b1; issue_rd = 5'd0; rs2_addr = 5'd7;
        #1;
        check("t3_cnt7", 32'(dut.cnt[7]), 1);
        check("t3_busy2", 32'(rs2_busy), 0);
        check("t3_stall", 32'(issue_stall), 0);
        cyc();
        wb(5'd7);
        check("t3_cnt7_wb", 32'(dut.cnt[7]), 0);

        // Saturation and simultaneous inc/dec
        issue(5'd3, 1'b0);
        issue(5'd3, 1'b0);
        issue(5'd3, 1'b0);
        check("t4_cnt3_full", 32'(dut.cnt[3]), 3);
        issue_valid = 1'b1; issue_rd = 5'd3;
        #1;
        check("t4_sat_stall", 32'(issue_stall), 1);
        cyc();
        check("t4_cnt3_sat", 32'(dut.cnt[3]), 3);
        issue_valid = 1'b1; issue_rd = 5'd3; wb_valid = 1'b1; wb_rd = 5'd3;
        #1;
        check("t4_sat_wb_stall", 32'(issue_stall), 0);
        cyc();
        idle();
        check("t4_cnt3_same", 32'(dut.cnt[3]), 3);
        check("t4_nf3", 32'(dut.nf[3]), 1);
        rs3_addr = 5'd3;
        #1;
        check("t4_busy3", 32'(rs3_busy), 1);
        wb(5'd3);
        wb(5'd3);
        wb(5'd3);
        check("t4_cnt3_drain", 32'(dut.cnt[3]), 0);
        check("t4_err", 32'(sb_err), 0);

        // Kill and writeback to the same register
        issue(5'd9, 1'b0);
        issue(5'd9, 1'b0);
        check("t5_cnt9", 32'(dut.cnt[9]), 2);
        kill_valid = 1'b1; kill_rd = 5'd9; wb_valid = 1'b1; wb_rd = 5'd9; rs1_addr = 5'd9;
        #1;
        check("t5_busy_pre", 32'(rs1_busy), 1);
        cyc();
        idle();
        rs1_addr = 5'd9;
        #1;
        check("t5_cnt9_zero", 32'(dut.cnt[9]), 0);
        check("t5_nf9_zero", 32'(dut.nf[9]), 0);
        check("t5_busy_post", 32'(rs1_busy), 0);
        check("t5_err", 32'(sb_err), 0);

        // x0 and underflow
        issue(5'd0, 1'b0);
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        check("t6_x0_busy", 32'(rs1_busy), 0);
        check("t6_x0_stall", 32'(issue_stall), 0);
        idle();
        wb_valid = 1'b1; wb_rd = 5'd4;
        #1;
        check("t6_err_pre", 32'(sb_err), 0);
        cyc();
        idle();
        check("t6_err_set", 32'(sb_err), 1);
        check("t6_cnt4", 32'(dut.cnt[4]), 0);
        cyc();
        cyc();
        check("t6_err_hold", 32'(sb_err), 1);
        rst_n = 1'b0;
        #1;
        check("t6_err_rst", 32'(sb_err), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("t6_err_after_rst", 32'(sb_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
